// File: rtl/mem_seq_controller.sv
// mem_seq_controller: strobe sequencer for two memories. It loads DEPTH_A words into A,
// waits GAP pipeline cycles, then writes NUM_B results into B as WEB/IncB pairs.
// A start/busy/done handshake, a hold (stall) input and a run-relative cycle counter
// sit around that sequence.
// Optional feature: define MEM_SEQ_AUTO_RESTART_EN so that DONE goes straight back to
// LOAD. After the first start the block then runs continuously.
module mem_seq_controller #(
  parameter int unsigned DEPTH_A = 8,
  parameter int unsigned GAP     = 2,
  parameter int unsigned NUM_B   = 4,
  parameter int unsigned CNT_W   = 5
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             start,
  input  logic             hold,
  output logic             WEA,
  output logic             IncA,
  output logic             WEB,
  output logic             IncB,
  output logic [CNT_W-1:0] counter,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PROC_LEN  = 2 * NUM_B;
  localparam int unsigned PH_MAX_AG = (DEPTH_A > GAP) ? DEPTH_A : GAP;
  localparam int unsigned PH_MAX    = (PH_MAX_AG > PROC_LEN) ? PH_MAX_AG : PROC_LEN;
  localparam int unsigned PH_W      = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_GAP  = 3'd2,
    S_PROC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            r_state;
  logic [PH_W-1:0]   r_phase;
  logic [CNT_W-1:0]  r_counter;
  logic              r_wea;
  logic              r_inca;
  logic              r_web;
  logic              r_incb;
  logic              r_busy;
  logic              r_done;

  state_t            w_state_nxt;
  logic [PH_W-1:0]   w_phase_nxt;
  logic [CNT_W-1:0]  w_counter_nxt;
  logic [3:0]        w_strobe_nxt;
  logic              w_busy_nxt;

  // Strobe pattern {WEA, IncA, WEB, IncB} for a given state and phase parity.
  function automatic logic [3:0] f_strobes(input state_t s, input logic odd);
    logic [3:0] v;
    v = 4'b0000;
    case (s)
      S_LOAD:  v = 4'b1100;
      S_GAP:   v = 4'b0100;
      S_PROC:  v = odd ? 4'b0001 : 4'b0110;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  // Sequencer next-state: phase counts within the state, and everything freezes under hold.
  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_counter_nxt = r_counter;
    case (r_state)
      S_IDLE: begin
        w_phase_nxt   = '0;
        w_counter_nxt = '0;
        if (start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (!hold) begin
          w_counter_nxt = r_counter + CNT_W'(1);
          if (r_phase == PH_W'(DEPTH_A - 1)) begin
            w_phase_nxt = '0;
            w_state_nxt = (GAP == 0) ? S_PROC : S_GAP;
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
          end
        end
      end
      S_GAP: begin
        if (!hold) begin
          w_counter_nxt = r_counter + CNT_W'(1);
          if (r_phase == PH_W'(GAP - 1)) begin
            w_phase_nxt = '0;
            w_state_nxt = S_PROC;
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
          end
        end
      end
      S_PROC: begin
        if (!hold) begin
          // The last PROC cycle leaves the counter on its final index for DONE.
          if (r_phase == PH_W'(PROC_LEN - 1)) begin
            w_phase_nxt = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_phase_nxt   = r_phase + PH_W'(1);
            w_counter_nxt = r_counter + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (!hold) begin
          w_phase_nxt   = '0;
          w_counter_nxt = '0;
`ifdef MEM_SEQ_AUTO_RESTART_EN
          w_state_nxt   = S_LOAD;
`else
          w_state_nxt   = S_IDLE;
`endif
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_phase_nxt   = '0;
        w_counter_nxt = '0;
      end
    endcase
  end

  // Output decode of the upcoming state, so that every output comes from a flop.
  always_comb begin
    w_strobe_nxt = f_strobes(w_state_nxt, w_phase_nxt[0]);
`ifdef MEM_SEQ_AUTO_RESTART_EN
    w_busy_nxt   = (w_state_nxt != S_IDLE);
`else
    w_busy_nxt   = (w_state_nxt == S_LOAD) || (w_state_nxt == S_GAP) || (w_state_nxt == S_PROC);
`endif
  end

  // State, phase, counter and registered outputs.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_counter <= '0;
      r_wea     <= 1'b0;
      r_inca    <= 1'b0;
      r_web     <= 1'b0;
      r_incb    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_counter <= w_counter_nxt;
      {r_wea, r_inca, r_web, r_incb} <= w_strobe_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= (w_state_nxt == S_DONE);
    end
  end

  // hold masks the strobes in the same cycle; state already freezes in the next-state logic.
  assign WEA     = r_wea  & ~hold;
  assign IncA    = r_inca & ~hold;
  assign WEB     = r_web  & ~hold;
  assign IncB    = r_incb & ~hold;
  assign counter = r_counter;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
